// File: rtl/decoder_pipe_if.sv
// Handshake and decoded-field bundle between fetch, decoder_pipe and execute.
// slave: decoder view (inputs: instr/valid/flush/dec_ready; outputs: the rest); master: mirror.
interface decoder_pipe_if;
    logic [31:0] instr_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic        flush_in;
    logic        dec_ready_in;
    logic        dec_valid_out;
    logic [4:0]  rd_addr_out;
    logic [4:0]  rs1_addr_out;
    logic [4:0]  rs2_addr_out;
    logic [31:0] instr_out;
    logic [4:0]  alu_opcode_out;
    logic [2:0]  imm_type_out;
    logic [2:0]  wb_mux_sel_out;
    logic [2:0]  csr_op_out;
    logic [1:0]  load_size_out;
    logic        load_unsigned_out;
    logic        mem_wr_req_out;
    logic        alu_src_out;
    logic        iadder_src_out;
    logic        rf_wr_en_out;
    logic        csr_wr_en_out;
    logic        illegal_instr_out;

    modport slave (
        input  instr_in, instr_valid_in, flush_in, dec_ready_in,
        output instr_ready_out, dec_valid_out,
        output rd_addr_out, rs1_addr_out, rs2_addr_out, instr_out,
        output alu_opcode_out, imm_type_out, wb_mux_sel_out, csr_op_out,
        output load_size_out, load_unsigned_out, mem_wr_req_out,
        output alu_src_out, iadder_src_out, rf_wr_en_out,
        output csr_wr_en_out, illegal_instr_out
    );

    modport master (
        output instr_in, instr_valid_in, flush_in, dec_ready_in,
        input  instr_ready_out, dec_valid_out,
        input  rd_addr_out, rs1_addr_out, rs2_addr_out, instr_out,
        input  alu_opcode_out, imm_type_out, wb_mux_sel_out, csr_op_out,
        input  load_size_out, load_unsigned_out, mem_wr_req_out,
        input  alu_src_out, iadder_src_out, rf_wr_en_out,
        input  csr_wr_en_out, illegal_instr_out
    );
endinterface

// File: rtl/decoder_pipe.sv
// Registered RV32I(+M, +FENCE) decoder with a 1- or 2-entry output skid buffer.
// Ports: clk_in, rst_in (sync, active-high), bus (decoder_pipe_if.slave).
module decoder_pipe #(
    parameter bit EN_M     = 1'b1,
    parameter bit EN_FENCE = 1'b1,
    parameter bit SKID     = 1'b1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    decoder_pipe_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;
    localparam logic [2:0] IMM_C = 3'b110;

    localparam logic [2:0] WB_LOAD  = 3'b001;
    localparam logic [2:0] WB_LUI   = 3'b010;
    localparam logic [2:0] WB_AUIPC = 3'b011;
    localparam logic [2:0] WB_CSR   = 3'b100;
    localparam logic [2:0] WB_PC4   = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] instr;
        logic [4:0]  alu_op;
        logic [2:0]  imm_type;
        logic [2:0]  wb_sel;
        logic [2:0]  csr_op;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic        mem_wr;
        logic        alu_src;
        logic        iadder_src;
        logic        rf_wr;
        logic        csr_wr;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    dec_t   dec, out_q, skid_q, vis;
    logic   accept, drain;
    logic   load_out, load_skid, out_from_skid;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill, wr, st, cw;

    assign opc = bus.instr_in[6:0];
    assign f3  = bus.instr_in[14:12];
    assign f7  = bus.instr_in[31:25];

    always_comb begin
        dec               = '0;
        dec.rd            = bus.instr_in[11:7];
        dec.rs1           = bus.instr_in[19:15];
        dec.rs2           = bus.instr_in[24:20];
        dec.instr         = bus.instr_in;
        dec.alu_op[2:0]   = f3;
        dec.csr_op        = f3;
        dec.load_size     = f3[1:0];
        dec.load_unsigned = f3[2];
        ill = 1'b0;
        wr  = 1'b0;
        st  = 1'b0;
        cw  = 1'b0;
        // Opcodes with bits [1:0] != 11 never match and fall to default.
        case (opc)
            OPC_LUI: begin
                dec.imm_type = IMM_U;
                dec.wb_sel   = WB_LUI;
                wr           = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm_type = IMM_U;
                dec.wb_sel   = WB_AUIPC;
                wr           = 1'b1;
            end
            OPC_JAL: begin
                dec.imm_type = IMM_J;
                dec.wb_sel   = WB_PC4;
                wr           = 1'b1;
            end
            OPC_JALR: begin
                dec.imm_type   = IMM_I;
                dec.wb_sel     = WB_PC4;
                dec.iadder_src = 1'b1;
                wr             = 1'b1;
                ill            = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm_type = IMM_B;
                ill          = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec.imm_type   = IMM_I;
                dec.wb_sel     = WB_LOAD;
                dec.iadder_src = 1'b1;
                wr             = 1'b1;
                ill            = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.imm_type   = IMM_S;
                dec.iadder_src = 1'b1;
                st             = 1'b1;
                ill            = (f3 >= 3'b011);
            end
            OPC_OPIMM: begin
                dec.imm_type = IMM_I;
                wr           = 1'b1;
                if (f3 == 3'b001) begin
                    ill = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    // Only shifts carry the arithmetic qualifier; ADDI's bit 30 is immediate.
                    dec.alu_op[3] = f7[5];
                    ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                dec.alu_src   = 1'b1;
                wr            = 1'b1;
                dec.alu_op[3] = f7[5];
                if (f7 == 7'b0000001) begin
                    dec.alu_op[4] = EN_M;
                    ill           = !EN_M;
                end else if (f7 == 7'b0100000) begin
                    ill = (f3 != 3'b000) && (f3 != 3'b101);
                end else begin
                    ill = (f7 != 7'b0000000);
                end
            end
            OPC_MISC: begin
                ill = !EN_FENCE || (f3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else if (f3 != 3'b000) begin
                    dec.imm_type = IMM_C;
                    dec.wb_sel   = WB_CSR;
                    wr           = 1'b1;
                    cw           = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        // Illegal words still flow downstream but must not change state.
        dec.illegal = ill;
        dec.rf_wr   = wr & ~ill;
        dec.mem_wr  = st & ~ill;
        dec.csr_wr  = cw & ~ill;
    end

    assign bus.instr_ready_out = SKID ? (state_q != FULL)
                               : (state_q == EMPTY) ||
                                 ((state_q == ONE) && bus.dec_ready_in);
    assign bus.dec_valid_out = (state_q != EMPTY);

    assign accept = bus.instr_valid_in && bus.instr_ready_out;
    assign drain  = bus.dec_valid_out && bus.dec_ready_in;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d       = ONE;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush_in) begin
            state_d       = EMPTY;
            load_out      = 1'b0;
            load_skid     = 1'b0;
            out_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= dec;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    // Stale register contents are hidden while nothing valid is held.
    assign vis = bus.dec_valid_out ? out_q : '0;

    assign bus.rd_addr_out       = vis.rd;
    assign bus.rs1_addr_out      = vis.rs1;
    assign bus.rs2_addr_out      = vis.rs2;
    assign bus.instr_out         = vis.instr;
    assign bus.alu_opcode_out    = vis.alu_op;
    assign bus.imm_type_out      = vis.imm_type;
    assign bus.wb_mux_sel_out    = vis.wb_sel;
    assign bus.csr_op_out        = vis.csr_op;
    assign bus.load_size_out     = vis.load_size;
    assign bus.load_unsigned_out = vis.load_unsigned;
    assign bus.mem_wr_req_out    = vis.mem_wr;
    assign bus.alu_src_out       = vis.alu_src;
    assign bus.iadder_src_out    = vis.iadder_src;
    assign bus.rf_wr_en_out      = vis.rf_wr;
    assign bus.csr_wr_en_out     = vis.csr_wr;
    assign bus.illegal_instr_out = vis.illegal;
endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe: a full-featured SKID=1 instance (a)
// and a reduced EN_M=0/EN_FENCE=0/SKID=0 instance (b) share one input stream.
module tb_decoder_pipe;
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [2:0]  imm;
        logic [2:0]  wb;
        logic [2:0]  csr;
        logic [1:0]  lsz;
        logic        lun;
        logic        mw;
        logic        asrc;
        logic        iasrc;
        logic        rf;
        logic        cw;
        logic        ill;
    } exp_t;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SUB  = 32'h40208033;
    localparam logic [31:0] SRAI = 32'h4010D093;
    localparam logic [31:0] MUL  = 32'h02208033;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        dready = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [6:0]  opc_tab [0:10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                   7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};

    always #5 clk = ~clk;

    decoder_pipe_if ia();
    decoder_pipe_if ib();

    assign ia.instr_in       = instr;
    assign ia.instr_valid_in = valid;
    assign ia.flush_in       = flush;
    assign ia.dec_ready_in   = dready;
    assign ib.instr_in       = instr;
    assign ib.instr_valid_in = valid;
    assign ib.flush_in       = flush;
    assign ib.dec_ready_in   = dready;

    decoder_pipe #(.EN_M(1'b1), .EN_FENCE(1'b1), .SKID(1'b1)) u_a (
        .clk_in(clk), .rst_in(rst), .bus(ia)
    );
    decoder_pipe #(.EN_M(1'b0), .EN_FENCE(1'b0), .SKID(1'b0)) u_b (
        .clk_in(clk), .rst_in(rst), .bus(ib)
    );

    // Reference: each instance is a FIFO of accepted words, depth 2 or 1.
    function automatic bit exp_rdy_a();
        return qa.size() < 2;
    endfunction

    function automatic bit exp_rdy_b();
        return (qb.size() == 0) || ((qb.size() == 1) && dready);
    endfunction

    bit m_acc_a, m_acc_b, m_dr_a, m_dr_b;
    always @(posedge clk) begin
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            m_acc_a = valid && exp_rdy_a();
            m_acc_b = valid && exp_rdy_b();
            m_dr_a  = (qa.size() > 0) && dready;
            m_dr_b  = (qb.size() > 0) && dready;
            if (m_dr_a) void'(qa.pop_front());
            if (m_dr_b) void'(qb.pop_front());
            if (m_acc_a) qa.push_back(instr);
            if (m_acc_b) qb.push_back(instr);
        end
    end

    function automatic exp_t ref_decode(input logic [31:0] w, input bit en_m,
                                        input bit en_fence);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal, wr, st, cs;
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.rd = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.instr = w;
        e.alu[2:0] = f3;
        e.csr = f3;
        e.lsz = f3[1:0];
        e.lun = f3[2];
        legal = 1;
        wr = 0;
        st = 0;
        cs = 0;
        case (w[6:0])
            7'h37: begin e.imm = 4; e.wb = 2; wr = 1; end
            7'h17: begin e.imm = 4; e.wb = 3; wr = 1; end
            7'h6f: begin e.imm = 5; e.wb = 5; wr = 1; end
            7'h67: begin
                e.imm = 1; e.wb = 5; e.iasrc = 1; wr = 1;
                legal = (f3 == 0);
            end
            7'h63: begin e.imm = 3; legal = !(f3 inside {3'd2, 3'd3}); end
            7'h03: begin
                e.imm = 1; e.wb = 1; e.iasrc = 1; wr = 1;
                legal = !(f3 inside {3'd3, 3'd6, 3'd7});
            end
            7'h23: begin e.imm = 2; e.iasrc = 1; st = 1; legal = (f3 < 3); end
            7'h13: begin
                e.imm = 1; wr = 1;
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) begin
                    legal = (f7 == 0) || (f7 == 7'h20);
                    e.alu[3] = f7[5];
                end
            end
            7'h33: begin
                e.asrc = 1; wr = 1;
                e.alu[3] = f7[5];
                e.alu[4] = en_m && (f7 == 1);
                legal = (f7 == 0) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5}))
                        || ((f7 == 1) && en_m);
            end
            7'h0f: legal = en_fence && (f3 < 2);
            7'h73: begin
                if (f3 == 4) legal = 0;
                else if (f3 != 0) begin
                    e.imm = 6; e.wb = 4; wr = 1; cs = 1;
                end
            end
            default: legal = 0;
        endcase
        e.ill = !legal;
        e.rf = wr && legal;
        e.mw = st && legal;
        e.cw = cs && legal;
        return e;
    endfunction

    function automatic exp_t act_a();
        return {ia.rd_addr_out, ia.rs1_addr_out, ia.rs2_addr_out, ia.instr_out,
                ia.alu_opcode_out, ia.imm_type_out, ia.wb_mux_sel_out,
                ia.csr_op_out, ia.load_size_out, ia.load_unsigned_out,
                ia.mem_wr_req_out, ia.alu_src_out, ia.iadder_src_out,
                ia.rf_wr_en_out, ia.csr_wr_en_out, ia.illegal_instr_out};
    endfunction

    function automatic exp_t act_b();
        return {ib.rd_addr_out, ib.rs1_addr_out, ib.rs2_addr_out, ib.instr_out,
                ib.alu_opcode_out, ib.imm_type_out, ib.wb_mux_sel_out,
                ib.csr_op_out, ib.load_size_out, ib.load_unsigned_out,
                ib.mem_wr_req_out, ib.alu_src_out, ib.iadder_src_out,
                ib.rf_wr_en_out, ib.csr_wr_en_out, ib.illegal_instr_out};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) w[6:0] = opc_tab[k];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // Applies inputs just after a falling edge; outputs then reflect the
    // state left by the preceding rising edge.
    task automatic cyc(input logic v, input logic [31:0] w, input logic dr,
                       input logic fl);
        @(negedge clk);
        valid = v;
        instr = w;
        dready = dr;
        flush = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1, $urandom, 0, 0);
        cyc(1, $urandom, 1, 0);
        cyc(0, '0, 0, 0);
        rst = 1'b0;
        checks++;
        if (ia.dec_valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid_a got %b want 0", ia.dec_valid_out);
        end
        checks++;
        if (ia.instr_ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_ready_a got %b want 1", ia.instr_ready_out);
        end
        checks++;
        if (act_a() !== '0) begin
            errors++; $display("FAIL reset_outs_a got %h want 0", act_a());
        end
        checks++;
        if (ib.dec_valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid_b got %b want 0", ib.dec_valid_out);
        end
        checks++;
        if (ib.instr_ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_ready_b got %b want 1", ib.instr_ready_out);
        end
        checks++;
        if (act_b() !== '0) begin
            errors++; $display("FAIL reset_outs_b got %h want 0", act_b());
        end
    endtask

    task automatic test_addi();
        cyc(1, ADDI, 1, 0);
        checks++;
        if (ia.dec_valid_out !== 1'b0) begin
            errors++; $display("FAIL addi_early got %b want 0", ia.dec_valid_out);
        end
        cyc(0, '0, 1, 0);
        checks++;
        if (ia.dec_valid_out !== 1'b1) begin
            errors++; $display("FAIL addi_valid got %b want 1", ia.dec_valid_out);
        end
        checks++;
        if ({ia.imm_type_out, ia.rf_wr_en_out, ia.alu_src_out, ia.alu_opcode_out}
            !== {3'b001, 1'b1, 1'b0, 5'b00000}) begin
            errors++;
            $display("FAIL addi_fields got imm=%b rf=%b src=%b alu=%b want 001 1 0 00000",
                     ia.imm_type_out, ia.rf_wr_en_out, ia.alu_src_out, ia.alu_opcode_out);
        end
        checks++;
        if (act_a() !== ref_decode(ADDI, 1, 1)) begin
            errors++; $display("FAIL addi_all got %h want %h", act_a(), ref_decode(ADDI, 1, 1));
        end
        cyc(0, '0, 1, 0);
        checks++;
        if (ia.dec_valid_out !== 1'b0) begin
            errors++; $display("FAIL addi_dup got %b want 0", ia.dec_valid_out);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, SUB, 0, 0);
        cyc(1, SRAI, 0, 0);
        checks++;
        if ({ia.instr_ready_out, ib.instr_ready_out} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_one_ready got a=%b b=%b want a=1 b=0",
                     ia.instr_ready_out, ib.instr_ready_out);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, i == 2, 0);
            checks++;
            if ({ia.instr_ready_out, ia.dec_valid_out, ia.alu_opcode_out, ia.instr_out}
                !== {1'b0, 1'b1, 5'b01000, SUB}) begin
                errors++;
                $display("FAIL b2b_hold%0d got rdy=%b v=%b alu=%b ins=%h want 0 1 01000 %h",
                         i, ia.instr_ready_out, ia.dec_valid_out, ia.alu_opcode_out,
                         ia.instr_out, SUB);
            end
        end
        cyc(0, '0, 1, 0);
        checks++;
        if ({ia.dec_valid_out, ia.alu_opcode_out, ia.instr_out}
            !== {1'b1, 5'b01101, SRAI}) begin
            errors++;
            $display("FAIL b2b_srai got v=%b alu=%b ins=%h want 1 01101 %h",
                     ia.dec_valid_out, ia.alu_opcode_out, ia.instr_out, SRAI);
        end
        cyc(0, '0, 1, 0);
        checks++;
        if (ia.dec_valid_out !== 1'b0) begin
            errors++; $display("FAIL b2b_drained got %b want 0", ia.dec_valid_out);
        end
    endtask

    task automatic test_mul();
        cyc(1, MUL, 1, 0);
        cyc(0, '0, 1, 0);
        checks++;
        if ({ia.alu_opcode_out, ia.illegal_instr_out, ia.rf_wr_en_out}
            !== {5'b10000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mul_a got alu=%b ill=%b rf=%b want 10000 0 1",
                     ia.alu_opcode_out, ia.illegal_instr_out, ia.rf_wr_en_out);
        end
        checks++;
        if ({ib.dec_valid_out, ib.illegal_instr_out, ib.rf_wr_en_out, ib.alu_opcode_out[4]}
            !== 4'b1100) begin
            errors++;
            $display("FAIL mul_b got v=%b ill=%b rf=%b m=%b want 1 1 0 0",
                     ib.dec_valid_out, ib.illegal_instr_out, ib.rf_wr_en_out,
                     ib.alu_opcode_out[4]);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w [0:3];
        w = '{32'h00000000, 32'h00007003, 32'h00003023, 32'h000010E7};
        for (int i = 0; i <= 4; i++) begin
            cyc(i < 4, (i < 4) ? w[i % 4] : 32'h0, 1, 0);
            if (i > 0) begin
                checks++;
                if ({ia.dec_valid_out, ia.illegal_instr_out, ia.rf_wr_en_out,
                     ia.mem_wr_req_out, ia.csr_wr_en_out} !== 5'b11000) begin
                    errors++;
                    $display("FAIL illegal_%0d got v=%b ill=%b rf=%b mw=%b cw=%b want 1 1 0 0 0",
                             i - 1, ia.dec_valid_out, ia.illegal_instr_out,
                             ia.rf_wr_en_out, ia.mem_wr_req_out, ia.csr_wr_en_out);
                end
            end
        end
    endtask

    task automatic test_flush();
        cyc(1, ADDI, 0, 0);
        cyc(1, SUB, 0, 0);
        cyc(1, SRAI, 0, 1);
        checks++;
        if ({ia.instr_ready_out, ia.dec_valid_out} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full got rdy=%b v=%b want 0 1",
                     ia.instr_ready_out, ia.dec_valid_out);
        end
        cyc(1, MUL, 0, 1);
        checks++;
        if ({ia.instr_ready_out, ia.dec_valid_out, ib.dec_valid_out} !== 3'b100) begin
            errors++;
            $display("FAIL flush_empty got rdy=%b va=%b vb=%b want 1 0 0",
                     ia.instr_ready_out, ia.dec_valid_out, ib.dec_valid_out);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, '0, 1, 0);
            checks++;
            if ({ia.dec_valid_out, ib.dec_valid_out} !== 2'b00) begin
                errors++;
                $display("FAIL flush_gone%0d got va=%b vb=%b want 0 0",
                         i, ia.dec_valid_out, ib.dec_valid_out);
            end
        end
    endtask

    task automatic test_skid0_stream();
        logic [31:0] prev;
        prev = '0;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] w;
            w = rand_instr();
            cyc(1, w, 1, 0);
            checks++;
            if (ib.instr_ready_out !== 1'b1) begin
                errors++; $display("FAIL stream_ready%0d got %b want 1", i, ib.instr_ready_out);
            end
            if (i > 0) begin
                checks++;
                if ({ib.dec_valid_out, act_b()} !== {1'b1, ref_decode(prev, 0, 0)}) begin
                    errors++;
                    $display("FAIL stream_out%0d got v=%b %h want 1 %h", i,
                             ib.dec_valid_out, act_b(), ref_decode(prev, 0, 0));
                end
            end
            prev = w;
        end
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 4) != 0, rand_instr(), ($urandom % 3) != 0,
                ($urandom % 40) == 0);
            checks++;
            if ({ia.instr_ready_out, ia.dec_valid_out} !== {exp_rdy_a(), qa.size() != 0}) begin
                errors++;
                $display("FAIL rand_hs_a cyc %0d got rdy=%b v=%b want %b %b", i,
                         ia.instr_ready_out, ia.dec_valid_out, exp_rdy_a(), qa.size() != 0);
            end
            checks++;
            if ({ib.instr_ready_out, ib.dec_valid_out} !== {exp_rdy_b(), qb.size() != 0}) begin
                errors++;
                $display("FAIL rand_hs_b cyc %0d got rdy=%b v=%b want %b %b", i,
                         ib.instr_ready_out, ib.dec_valid_out, exp_rdy_b(), qb.size() != 0);
            end
            if (qa.size() != 0) begin
                checks++;
                if (act_a() !== ref_decode(qa[0], 1, 1)) begin
                    errors++;
                    $display("FAIL rand_dec_a cyc %0d got %h want %h", i, act_a(),
                             ref_decode(qa[0], 1, 1));
                end
            end
            if (qb.size() != 0) begin
                checks++;
                if (act_b() !== ref_decode(qb[0], 0, 0)) begin
                    errors++;
                    $display("FAIL rand_dec_b cyc %0d got %h want %h", i, act_b(),
                             ref_decode(qb[0], 0, 0));
                end
            end
            rst = (($urandom % 150) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_mul();
        test_illegal();
        test_flush();
        test_skid0_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
